exc_redirect_ctrl: RTL and testbench

- Sequential counterpart to the instruction control decoder. It consumes the decoder's Halt, SIIC, RTI and err outputs for the instruction in EX and produces the decoder's Valid_PC input.
- Holds the EPC register and the in-handler flag.
- Issues registered PC redirects to the SIIC vector or back to EPC, flushes younger pipeline stages, and latches the processor into a halted state.
- Sits between the decode/execute stages and the fetch PC mux.

---
 rtl/exc_redirect_ctrl_if.sv | 39 +++
 rtl/exc_redirect_ctrl.sv | 138 +++++++++++++
 tb/tb_exc_redirect_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/exc_redirect_ctrl_if.sv
// rtl/exc_redirect_ctrl_if.sv - EX-stage event inputs and redirect/flush outputs of the exception controller
`timescale 1ns/1ps

interface exc_redirect_ctrl_if #(
  parameter int WIDTH = 16
) ();

  // Pipeline side: decoder outputs for the instruction currently in EX
  logic             Inst_Valid;
  logic             Stall;
  logic             Halt;
  logic             SIIC;
  logic             RTI;
  logic             Err_In;
  logic [WIDTH-1:0] PC_Plus2;

  // Controller side: fetch control and architectural exception state
  logic             Valid_PC;
  logic             Redirect;
  logic [WIDTH-1:0] Redirect_PC;
  logic             Flush;
  logic [WIDTH-1:0] EPC;
  logic             In_Handler;
  logic             Halted;
  logic             Err;

  // Pipeline / decode stages drive events and observe redirects
  modport master (
    output Inst_Valid, Stall, Halt, SIIC, RTI, Err_In, PC_Plus2,
    input  Valid_PC, Redirect, Redirect_PC, Flush, EPC, In_Handler, Halted, Err
  );

  // The exception controller consumes events and drives redirects
  modport slave (
    input  Inst_Valid, Stall, Halt, SIIC, RTI, Err_In, PC_Plus2,
    output Valid_PC, Redirect, Redirect_PC, Flush, EPC, In_Handler, Halted, Err
  );

endinterface

// File: rtl/exc_redirect_ctrl.sv
// rtl/exc_redirect_ctrl.sv - EPC/handler state, SIIC/RTI PC redirects, pipeline flush and halt latch
`timescale 1ns/1ps

module exc_redirect_ctrl #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] VEC_ADDR     = 16'h0002,
  parameter int               FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  exc_redirect_ctrl_if.slave bus
);

  // Flush counter preload: the event edge itself supplies the first flush cycle
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       flush_cnt;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] redirect_pc;
  logic             in_handler;
  logic             halted;
  logic             err;
  logic             redirect;
  logic             flush;

  // Event qualification and decode of which single action wins this cycle
  logic accept;
  logic do_err;
  logic do_halt;
  logic do_vector;
  logic do_return;

  // Resolve Err_In > Halt > SIIC > RTI; illegal SIIC/RTI nesting folds into the error path
  always_comb begin
    accept    = 1'b0;
    do_err    = 1'b0;
    do_halt   = 1'b0;
    do_vector = 1'b0;
    do_return = 1'b0;
    accept    = (state == ST_RUN) && bus.Inst_Valid && !bus.Stall;
    if (accept) begin
      if (bus.Err_In) begin
        do_err = 1'b1;
      end else if (bus.Halt) begin
        do_halt = 1'b1;
      end else if (bus.SIIC) begin
        if (in_handler) do_err    = 1'b1;
        else            do_vector = 1'b1;
      end else if (bus.RTI) begin
        if (in_handler) do_return = 1'b1;
        else            do_err    = 1'b1;
      end
    end
  end

  // Controller state machine; every output except Valid_PC is a register here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      flush_cnt   <= 3'd0;
      epc         <= '0;
      redirect_pc <= '0;
      in_handler  <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
      redirect    <= 1'b0;
      flush       <= 1'b0;
    end else begin
      // Redirect is a single-cycle strobe regardless of stalls that follow
      redirect <= 1'b0;
      case (state)
        ST_RUN: begin
          if (do_err) begin
            err    <= 1'b1;
            halted <= 1'b1;
            flush  <= 1'b1;
            state  <= ST_HALT;
          end else if (do_halt) begin
            halted <= 1'b1;
            flush  <= 1'b1;
            state  <= ST_HALT;
          end else if (do_vector) begin
            epc         <= bus.PC_Plus2;
            in_handler  <= 1'b1;
            redirect_pc <= VEC_ADDR;
            redirect    <= 1'b1;
            flush       <= 1'b1;
            flush_cnt   <= CNT_INIT;
            state       <= ST_FLUSH;
          end else if (do_return) begin
            redirect_pc <= epc;
            in_handler  <= 1'b0;
            redirect    <= 1'b1;
            flush       <= 1'b1;
            flush_cnt   <= CNT_INIT;
            state       <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // A stall freezes the countdown so squashed stages stay squashed
          if (!bus.Stall) begin
            if (flush_cnt == 3'd0) begin
              flush <= 1'b0;
              state <= ST_RUN;
            end else begin
              flush_cnt <= flush_cnt - 3'd1;
            end
          end
        end
        ST_HALT: begin
          // Only the entry cycle flushes; afterwards sit idle until reset
          flush <= 1'b0;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  // Fetch may issue only while running normally
  assign bus.Valid_PC    = (state == ST_RUN);
  assign bus.Redirect    = redirect;
  assign bus.Redirect_PC = redirect_pc;
  assign bus.Flush       = flush;
  assign bus.EPC         = epc;
  assign bus.In_Handler  = in_handler;
  assign bus.Halted      = halted;
  assign bus.Err         = err;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// tb/tb_exc_redirect_ctrl.sv - randomized and directed self-checking bench for exc_redirect_ctrl
`timescale 1ns/1ps

module tb_exc_redirect_ctrl;

  localparam int          WIDTH = 16;
  localparam logic [15:0] VEC   = 16'h0002;
  localparam int          FC    = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  exc_redirect_ctrl_if #(.WIDTH(WIDTH)) bus ();

  exc_redirect_ctrl #(.WIDTH(WIDTH), .VEC_ADDR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: halted/flush bookkeeping expressed as remaining flush cycles
  logic [15:0] m_epc, m_rpc;
  logic        m_inh, m_halted, m_err, m_redirect, m_halt_flush;
  int          m_flush_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_epc = 0; m_rpc = 0; m_inh = 0; m_halted = 0; m_err = 0;
      m_redirect = 0; m_halt_flush = 0; m_flush_left = 0;
    end else begin
      logic acc, bad;
      acc = !m_halted && (m_flush_left == 0) && bus.Inst_Valid && !bus.Stall;
      m_redirect   = 0;
      m_halt_flush = 0;
      if (m_flush_left > 0 && !bus.Stall) m_flush_left--;
      if (acc) begin
        bad = bus.Err_In ||
              (!bus.Halt && bus.SIIC && m_inh) ||
              (!bus.Halt && !bus.SIIC && bus.RTI && !m_inh);
        if (bad) begin
          m_err = 1; m_halted = 1; m_halt_flush = 1;
        end else if (bus.Halt) begin
          m_halted = 1; m_halt_flush = 1;
        end else if (bus.SIIC) begin
          m_epc = bus.PC_Plus2; m_inh = 1; m_rpc = VEC;
          m_redirect = 1; m_flush_left = FC;
        end else if (bus.RTI) begin
          m_rpc = m_epc; m_inh = 0;
          m_redirect = 1; m_flush_left = FC;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_pc",    32'(bus.Valid_PC),    32'(!m_halted && m_flush_left == 0));
      check("redirect",    32'(bus.Redirect),    32'(m_redirect));
      check("redirect_pc", 32'(bus.Redirect_PC), 32'(m_rpc));
      check("flush",       32'(bus.Flush),       32'((m_flush_left > 0) || m_halt_flush));
      check("epc",         32'(bus.EPC),         32'(m_epc));
      check("in_handler",  32'(bus.In_Handler),  32'(m_inh));
      check("halted",      32'(bus.Halted),      32'(m_halted));
      check("err",         32'(bus.Err),         32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic iv, input logic st, input logic h, input logic s,
                       input logic r, input logic e, input logic [15:0] pc);
    bus.Inst_Valid = iv; bus.Stall = st; bus.Halt = h; bus.SIIC = s;
    bus.RTI = r; bus.Err_In = e; bus.PC_Plus2 = pc;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 16'h0000);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    cyc();
    cyc();
    rst_n = 1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 0;
    idle();
    cyc();
    check("reset_valid_pc", 32'(bus.Valid_PC), 32'd1);
    check("reset_flush",    32'(bus.Flush),    32'd0);
    do_reset();

    // Idle run: nothing happens for 10 cycles
    repeat (10) cyc();
    check("idle_valid_pc", 32'(bus.Valid_PC), 32'd1);
    check("idle_epc",      32'(bus.EPC),      32'h0);

    // SIIC then RTI then illegal RTI
    drive(1, 0, 0, 1, 0, 0, 16'h0124); cyc(); idle();
    check("siic_redirect",   32'(bus.Redirect),    32'd1);
    check("siic_target",     32'(bus.Redirect_PC), 32'h0002);
    check("siic_epc",        32'(bus.EPC),         32'h0124);
    check("siic_inh",        32'(bus.In_Handler),  32'd1);
    check("siic_valid_pc",   32'(bus.Valid_PC),    32'd0);
    cyc();
    check("siic_flush2",     32'(bus.Flush),       32'd1);
    check("siic_redir_off",  32'(bus.Redirect),    32'd0);
    cyc();
    check("siic_flush_done", 32'(bus.Flush),       32'd0);
    check("siic_run",        32'(bus.Valid_PC),    32'd1);
    drive(1, 0, 0, 0, 1, 0, 16'h0300); cyc(); idle();
    check("rti_redirect",    32'(bus.Redirect),    32'd1);
    check("rti_target",      32'(bus.Redirect_PC), 32'h0124);
    check("rti_inh",         32'(bus.In_Handler),  32'd0);
    cyc(); cyc();
    drive(1, 0, 0, 0, 1, 0, 16'h0300); cyc(); idle();
    check("rti2_err",        32'(bus.Err),         32'd1);
    check("rti2_halted",     32'(bus.Halted),      32'd1);
    check("rti2_flush",      32'(bus.Flush),       32'd1);
    check("rti2_no_redir",   32'(bus.Redirect),    32'd0);
    drive(1, 0, 0, 1, 0, 0, 16'h0500); cyc(); cyc();
    check("halt_ignores",    32'(bus.Redirect),    32'd0);
    check("halt_flush_off",  32'(bus.Flush),       32'd0);
    check("halt_valid_pc",   32'(bus.Valid_PC),    32'd0);

    // Stalled SIIC, then stall inside the flush window
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 16'h0124);
    repeat (3) begin
      cyc();
      check("stall_no_redir", 32'(bus.Redirect),   32'd0);
      check("stall_no_inh",   32'(bus.In_Handler), 32'd0);
    end
    bus.Stall = 0; cyc();
    check("unstall_redir", 32'(bus.Redirect), 32'd1);
    drive(1, 1, 0, 0, 0, 0, 16'h0000);
    cyc(); check("fstall_a", 32'(bus.Flush), 32'd1);
    cyc(); check("fstall_b", 32'(bus.Flush), 32'd1);
    idle();
    cyc(); check("fstall_c", 32'(bus.Flush), 32'd1);
    cyc(); check("fstall_d", 32'(bus.Flush), 32'd0);

    // Halt wins over SIIC
    do_reset();
    drive(1, 0, 1, 1, 0, 0, 16'h0040); cyc();
    drive(1, 0, 0, 1, 0, 1, 16'h0080);
    check("hs_halted",   32'(bus.Halted),   32'd1);
    check("hs_flush",    32'(bus.Flush),    32'd1);
    check("hs_no_redir", 32'(bus.Redirect), 32'd0);
    check("hs_epc",      32'(bus.EPC),      32'h0);
    cyc();
    check("hs_err_ign",  32'(bus.Err),      32'd0);
    check("hs_flush1",   32'(bus.Flush),    32'd0);

    // Nested SIIC
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 16'h0124); cyc(); idle(); cyc(); cyc();
    drive(1, 0, 0, 1, 0, 0, 16'h0200); cyc(); idle();
    check("nest_err",    32'(bus.Err),    32'd1);
    check("nest_halted", 32'(bus.Halted), 32'd1);
    check("nest_epc",    32'(bus.EPC),    32'h0124);

    // Asynchronous reset mid-flush
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 16'h0124); cyc(); idle();
    rst_n = 0;
    #1;
    check("arst_flush",   32'(bus.Flush),       32'd0);
    check("arst_redir",   32'(bus.Redirect),    32'd0);
    check("arst_rpc",     32'(bus.Redirect_PC), 32'h0);
    check("arst_epc",     32'(bus.EPC),         32'h0);
    check("arst_inh",     32'(bus.In_Handler),  32'd0);
    check("arst_valid",   32'(bus.Valid_PC),    32'd1);
    cyc();
    rst_n = 1;

    // Randomized episodes checked by the reference on every cycle
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3,
              16'($urandom) & 16'hfffe);
        cyc();
      end
    end

    idle();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
